sram_valrdy_adapter: RTL and testbench

//  Upstream stage of SramGenericPRTL: turns a val/rdy request stream into single-port SRAM

---
 rtl/sram_adapter_pkg.sv | 29 ++
 rtl/sram_resp_queue.sv | 87 ++++++++
 rtl/sram_valrdy_adapter.sv | 164 ++++++++++++++++
 tb/tb_sram_valrdy_adapter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_adapter_pkg.sv
// ----------------------------------------------------------------------------
// sram_adapter_pkg
//   Shared types for the val/rdy to single-port SRAM adapter.
//   - req_type_t  : request/response kind (READ / WRITE)
//   - resp_hdr_t  : response header {type, opaque tag}; the data field width
//                   depends on the SRAM word width, so the full entry struct
//                   is declared inside the adapter using this header.
//   - OPQ_W       : opaque tag width
// ----------------------------------------------------------------------------
package sram_adapter_pkg;

    localparam int OPQ_W = 8;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_t;

    typedef struct packed {
        req_type_t          rtype;
        logic [OPQ_W-1:0]   opq;
    } resp_hdr_t;

    // True when one more entry may be admitted without exceeding depth.
    function automatic logic credit_ok(input int unsigned used, input int unsigned depth);
        return (used < depth);
    endfunction

endpackage

// File: rtl/sram_resp_queue.sv
// ----------------------------------------------------------------------------
// sram_resp_queue
//   Plain DEPTH-entry FIFO (no bypass) holding SRAM responses.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     enq_val/enq_rdy   enqueue handshake, enq_data payload
//     deq_val/deq_rdy   dequeue handshake, deq_data payload (head entry)
//     occ               current number of stored entries
//   Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// ----------------------------------------------------------------------------
module sram_resp_queue #(
    parameter  int DEPTH = 3,
    parameter  int W     = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enq_val,
    output logic          enq_rdy,
    input  logic [W-1:0]  enq_data,
    output logic          deq_val,
    input  logic          deq_rdy,
    output logic [W-1:0]  deq_data,
    output logic [CW-1:0] occ
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic          enq_fire_s;
    logic          deq_fire_s;

    // Handshake and head-of-queue outputs from registered state.
    always_comb begin
        enq_rdy    = (occ_q != CW'(DEPTH));
        deq_val    = (occ_q != {CW{1'b0}});
        deq_data   = mem_q[rd_ptr_q];
        occ        = occ_q;
        enq_fire_s = enq_val & enq_rdy;
        deq_fire_s = deq_val & deq_rdy;
    end

    // Next pointer / occupancy; simultaneous enq+deq keeps occ unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (enq_fire_s) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (deq_fire_s) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({enq_fire_s, deq_fire_s})
            2'b10:   occ_d = occ_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   occ_d = occ_q - {{(CW-1){1'b0}}, 1'b1};
            default: occ_d = occ_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            occ_q    <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Entry storage; contents are meaningless while occ is zero, so no reset.
    always_ff @(posedge clk) begin
        if (enq_fire_s) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

endmodule

// File: rtl/sram_valrdy_adapter.sv
// ----------------------------------------------------------------------------
// sram_valrdy_adapter
//   Converts a val/rdy request stream into single-port SRAM macro pins and
//   returns read data (captured from O1 one cycle after the read) through a
//   response queue exposed as a val/rdy stream.
//   Ports:
//     clk, reset                 clock, asynchronous active-low reset
//     req_val/req_rdy            request handshake
//     req_type/addr/data/wmask/opq  request fields (type 0 = read, 1 = write)
//     resp_val/resp_rdy          response handshake
//     resp_type/opq/data         response fields (data is 0 for write acks)
//     A1 CSB1 WEB1 I1 WBM1 OEB1  SRAM macro inputs (active-low strobes)
//     O1                         SRAM read data
//   Configuration macro:
//     SRAM_WRITE_ACK_EN  when defined, writes also return an ack response
//                        and consume a queue credit; otherwise writes are
//                        fire-and-forget.
//   Admission is credit based: req_rdy is asserted only when the queue has
//   room for every response already in flight, so responses are never lost.
// ----------------------------------------------------------------------------
module sram_valrdy_adapter
    import sram_adapter_pkg::*;
#(
    parameter int num_bits   = 128,
    parameter int num_words  = 256,
    parameter int RESP_DEPTH = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_val,
    output logic                          req_rdy,
    input  logic                          req_type,
    input  logic [$clog2(num_words)-1:0]  req_addr,
    input  logic [num_bits-1:0]           req_data,
    input  logic [num_bits/8-1:0]         req_wmask,
    input  logic [OPQ_W-1:0]              req_opq,
    output logic                          resp_val,
    input  logic                          resp_rdy,
    output logic                          resp_type,
    output logic [OPQ_W-1:0]              resp_opq,
    output logic [num_bits-1:0]           resp_data,
    output logic [$clog2(num_words)-1:0]  A1,
    output logic                          CSB1,
    output logic                          WEB1,
    output logic [num_bits-1:0]           I1,
    output logic [num_bits-1:0]           WBM1,
    output logic                          OEB1,
    input  logic [num_bits-1:0]           O1
);

    localparam int NB = num_bits / 8;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    typedef struct packed {
        resp_hdr_t           hdr;
        logic [num_bits-1:0] data;
    } resp_entry_t;

    localparam int EW = $bits(resp_entry_t);

    logic             req_fire_s;
    logic             wr_fire_s;
    logic             s1_val_q, s1_val_d;
    req_type_t        s1_type_q, s1_type_d;
    logic [OPQ_W-1:0] s1_opq_q, s1_opq_d;
    logic             s1_enq_s;
    logic             q_enq_val_s;
    logic             q_enq_rdy_s;
    resp_entry_t      q_enq_data_s;
    logic [EW-1:0]    q_deq_data_s;
    resp_entry_t      q_head_s;
    logic [CW-1:0]    q_occ_s;
    logic [CW:0]      used_s;

    // Credit check: queued entries plus the one about to be enqueued from stage 1.
    always_comb begin
        used_s     = {1'b0, q_occ_s} + {{CW{1'b0}}, s1_enq_s};
        req_rdy    = reset & credit_ok(int'(used_s), RESP_DEPTH);
        req_fire_s = req_val & req_rdy;
        wr_fire_s  = req_fire_s & req_type;
    end

    // SRAM pins driven straight from the request, gated by the fire.
    always_comb begin
        CSB1 = ~req_fire_s;
        WEB1 = ~wr_fire_s;
        A1   = req_addr;
        I1   = req_data;
        WBM1 = {num_bits{1'b0}};
        for (int j = 0; j < NB; j++) begin
            WBM1[8*j +: 8] = {8{req_wmask[j] & wr_fire_s}};
        end
        OEB1 = ~(s1_val_q & (s1_type_q == READ));
    end

    // Stage-1 next state: remember what was issued to the SRAM this cycle.
    always_comb begin
        s1_val_d  = req_fire_s;
        s1_type_d = s1_type_q;
        s1_opq_d  = s1_opq_q;
        if (req_fire_s) begin
            s1_type_d = req_type_t'(req_type);
            s1_opq_d  = req_opq;
        end else begin
            s1_type_d = s1_type_q;
            s1_opq_d  = s1_opq_q;
        end
    end

    // Stage-1 registers; reset drops any request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val_q  <= 1'b0;
            s1_type_q <= READ;
            s1_opq_q  <= {OPQ_W{1'b0}};
        end else begin
            s1_val_q  <= s1_val_d;
            s1_type_q <= s1_type_d;
            s1_opq_q  <= s1_opq_d;
        end
    end

    // Which stage-1 operations produce a response entry.
    always_comb begin
`ifdef SRAM_WRITE_ACK_EN
        s1_enq_s = s1_val_q;
`else
        s1_enq_s = s1_val_q & (s1_type_q == READ);
`endif
    end

    // Build the queue entry; O1 is valid in the cycle after the read fire.
    always_comb begin
        q_enq_data_s.hdr.rtype = s1_type_q;
        q_enq_data_s.hdr.opq   = s1_opq_q;
        q_enq_data_s.data      = (s1_type_q == READ) ? O1 : {num_bits{1'b0}};
        // Credits guarantee q_enq_rdy_s here; the gate keeps the FIFO safe regardless.
        q_enq_val_s            = s1_enq_s & q_enq_rdy_s;
    end

    sram_resp_queue #(
        .DEPTH (RESP_DEPTH),
        .W     (EW)
    ) u_resp_queue (
        .clk      (clk),
        .rst_n    (reset),
        .enq_val  (q_enq_val_s),
        .enq_rdy  (q_enq_rdy_s),
        .enq_data (q_enq_data_s),
        .deq_val  (resp_val),
        .deq_rdy  (resp_rdy),
        .deq_data (q_deq_data_s),
        .occ      (q_occ_s)
    );

    // Unpack the queue head onto the response port.
    always_comb begin
        q_head_s  = resp_entry_t'(q_deq_data_s);
        resp_type = q_head_s.hdr.rtype;
        resp_opq  = q_head_s.hdr.opq;
        resp_data = q_head_s.data;
    end

endmodule

// File: tb/tb_sram_valrdy_adapter.sv
module tb_sram_valrdy_adapter;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_val;
    logic         req_rdy;
    logic         req_type;
    logic [7:0]   req_addr;
    logic [127:0] req_data;
    logic [15:0]  req_wmask;
    logic [7:0]   req_opq;
    logic         resp_val;
    logic         resp_rdy;
    logic         resp_type;
    logic [7:0]   resp_opq;
    logic [127:0] resp_data;
    logic [7:0]   A1;
    logic         CSB1;
    logic         WEB1;
    logic [127:0] I1;
    logic [127:0] WBM1;
    logic         OEB1;
    logic [127:0] O1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_valrdy_adapter dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_wmask (req_wmask),
        .req_opq   (req_opq),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_type (resp_type),
        .resp_opq  (resp_opq),
        .resp_data (resp_data),
        .A1        (A1),
        .CSB1      (CSB1),
        .WEB1      (WEB1),
        .I1        (I1),
        .WBM1      (WBM1),
        .OEB1      (OEB1),
        .O1        (O1)
    );

    // Behavioural single-port SRAM: synchronous, registered read, bit-masked write.
    logic [127:0] sram_mem [256];
    logic [127:0] sram_dout;
    initial begin
        for (int i = 0; i < 256; i++) sram_mem[i] = 128'h0;
        sram_dout = 128'h0;
    end
    always @(posedge clk) begin
        if (!CSB1) begin
            if (!WEB1) sram_mem[A1] <= (sram_mem[A1] & ~WBM1) | (I1 & WBM1);
            else       sram_dout   <= sram_mem[A1];
        end
    end
    assign O1 = OEB1 ? 128'h0 : sram_dout;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present a request and hold it until accepted; returns at cycle N+1.
    task automatic send(input string nm, input logic t, input logic [7:0] a,
                        input logic [127:0] d, input logic [15:0] m, input logic [7:0] o);
        logic ok;
        ok = 1'b0;
        req_type = t; req_addr = a; req_data = d; req_wmask = m; req_opq = o;
        req_val = 1'b1;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge clk);
            if (req_rdy) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        check({nm, "_accept"}, ok, 1'b1);
    endtask

    // Called at cycle N+1: no response yet, then one at N+2 which is consumed.
    task automatic expect_resp(input string nm, input logic t, input logic [7:0] o,
                               input logic [127:0] d);
        @(negedge clk);
        check({nm, "_early"}, resp_val, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check({nm, "_val"},  resp_val,  1'b1);
        check({nm, "_type"}, resp_type, t);
        check({nm, "_opq"},  resp_opq,  o);
        check({nm, "_data"}, resp_data, d);
        @(posedge clk); #1;
    endtask

    typedef struct {
        string        nm;
        logic         rtype;
        logic [7:0]   addr;
        logic [127:0] data;
        logic [15:0]  wmask;
        logic [7:0]   opq;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [10];
    logic [7:0]   b2b_addr [8];
    logic [127:0] b2b_exp  [8];
    logic [127:0] pat255;
    int           accepted;

    initial begin
        pat255 = 128'h0123456789ABCDEF_FEDCBA9876543210;
        vecs[0] = '{"wr_full",    1'b1, 8'd3,   {16{8'hA5}}, 16'hFFFF, 8'h01, 128'h0};
        vecs[1] = '{"rd_full",    1'b0, 8'd3,   128'h0,      16'h0000, 8'h02, {16{8'hA5}}};
        vecs[2] = '{"wr_byte0",   1'b1, 8'd3,   {16{8'h11}}, 16'h0001, 8'h03, 128'h0};
        vecs[3] = '{"rd_byte0",   1'b0, 8'd3,   128'h0,      16'h0000, 8'h04, {{15{8'hA5}}, 8'h11}};
        vecs[4] = '{"wr_nomask",  1'b1, 8'd5,   {16{8'hFF}}, 16'h0000, 8'h05, 128'h0};
        vecs[5] = '{"rd_nomask",  1'b0, 8'd5,   128'h0,      16'h0000, 8'h06, 128'h0};
        vecs[6] = '{"wr_top",     1'b1, 8'd255, pat255,      16'hFFFF, 8'h07, 128'h0};
        vecs[7] = '{"rd_top",     1'b0, 8'd255, 128'h0,      16'h0000, 8'h08, pat255};
        vecs[8] = '{"wr_byte15",  1'b1, 8'd0,   {16{8'hC3}}, 16'h8000, 8'h09, 128'h0};
        vecs[9] = '{"rd_byte15",  1'b0, 8'd0,   128'h0,      16'h0000, 8'h0A, {8'hC3, 120'h0}};
        for (int k = 0; k < 8; k++) begin
            case (k % 4)
                0:       begin b2b_addr[k] = 8'd3;   b2b_exp[k] = {{15{8'hA5}}, 8'h11}; end
                1:       begin b2b_addr[k] = 8'd5;   b2b_exp[k] = 128'h0;               end
                2:       begin b2b_addr[k] = 8'd255; b2b_exp[k] = pat255;               end
                default: begin b2b_addr[k] = 8'd0;   b2b_exp[k] = {8'hC3, 120'h0};      end
            endcase
        end

        // Reset state.
        reset = 1'b0; req_val = 1'b0; req_type = 1'b0; req_addr = 8'h0;
        req_data = 128'h0; req_wmask = 16'h0; req_opq = 8'h0; resp_rdy = 1'b1;
        #12;
        check("rst_req_rdy",  req_rdy,  1'b0);
        check("rst_resp_val", resp_val, 1'b0);
        check("rst_csb",      CSB1,     1'b1);
        check("rst_web",      WEB1,     1'b1);
        check("rst_oeb",      OEB1,     1'b1);
        check("rst_wbm",      WBM1,     128'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", req_rdy, 1'b1);
        @(posedge clk); #1;

        // Table-driven single transactions.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].nm, vecs[i].rtype, vecs[i].addr, vecs[i].data, vecs[i].wmask, vecs[i].opq);
            if (vecs[i].rtype == 1'b0) begin
                expect_resp(vecs[i].nm, 1'b0, vecs[i].opq, vecs[i].exp);
            end else begin
`ifdef SRAM_WRITE_ACK_EN
                expect_resp(vecs[i].nm, 1'b1, vecs[i].opq, 128'h0);
`else
                @(negedge clk); check({vecs[i].nm, "_noack1"}, resp_val, 1'b0);
                @(posedge clk); #1;
                @(negedge clk); check({vecs[i].nm, "_noack2"}, resp_val, 1'b0);
                @(posedge clk); #1;
`endif
            end
        end

        // Eight back-to-back reads with resp_rdy held high.
        resp_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                req_val = 1'b1; req_type = 1'b0; req_addr = b2b_addr[k]; req_opq = 8'h20 + 8'(k);
            end else begin
                req_val = 1'b0;
            end
            @(negedge clk);
            if (k < 8) check($sformatf("b2b_rdy%0d", k), req_rdy, 1'b1);
            if (k >= 2) begin
                check($sformatf("b2b_val%0d", k - 2),  resp_val,  1'b1);
                check($sformatf("b2b_opq%0d", k - 2),  resp_opq,  8'h20 + 8'(k - 2));
                check($sformatf("b2b_data%0d", k - 2), resp_data, b2b_exp[k - 2]);
            end
            @(posedge clk); #1;
        end

        // Back-pressure: only three reads may be admitted.
        resp_rdy = 1'b0; accepted = 0;
        for (int k = 0; k < 6; k++) begin
            req_val = 1'b1; req_type = 1'b0; req_addr = 8'd255; req_opq = 8'h40 + 8'(k);
            @(negedge clk);
            if (req_rdy) accepted++;
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        check("bp_accepted", 128'(accepted), 128'd3);
        @(negedge clk);
        check("bp_rdy_low", req_rdy, 1'b0);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("drain_val%0d", k),  resp_val,  1'b1);
            check($sformatf("drain_opq%0d", k),  resp_opq,  8'h40 + 8'(k));
            check($sformatf("drain_data%0d", k), resp_data, pat255);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("drain_empty", resp_val, 1'b0);
        check("drain_rdy",   req_rdy,  1'b1);
        @(posedge clk); #1;

        // Reset with two entries queued and one read in flight.
        resp_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_val = 1'b1; req_type = 1'b0; req_addr = 8'd3; req_opq = 8'h60 + 8'(k);
            @(negedge clk);
            check($sformatf("mid_rdy%0d", k), req_rdy, 1'b1);
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        @(negedge clk);
        check("mid_queued", resp_val, 1'b1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_val", resp_val, 1'b0);
        check("mid_rst_csb", CSB1,     1'b1);
        check("mid_rst_rdy", req_rdy,  1'b0);
        check("mid_rst_oeb", OEB1,     1'b1);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1; resp_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) check("mid_rel_rdy", req_rdy, 1'b1);
            check($sformatf("mid_stale%0d", k), resp_val, 1'b0);
            @(posedge clk); #1;
        end

        // Write to addr 7.
`ifdef SRAM_WRITE_ACK_EN
        send("wr7", 1'b1, 8'd7, {16{8'h5A}}, 16'hFFFF, 8'h77);
        expect_resp("wr7", 1'b1, 8'h77, 128'h0);
`else
        resp_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_val = 1'b1; req_type = 1'b1; req_addr = 8'd7; req_data = {16{8'h5A}};
            req_wmask = 16'hFFFF; req_opq = 8'h77;
            @(negedge clk);
            check($sformatf("wr7_rdy%0d", k), req_rdy,  1'b1);
            check($sformatf("wr7_web%0d", k), WEB1,     1'b0);
            check($sformatf("wr7_nov%0d", k), resp_val, 1'b0);
            @(posedge clk); #1;
        end
        req_val = 1'b0;
        @(negedge clk);
        check("wr7_noresp", resp_val, 1'b0);
        @(posedge clk); #1;
        resp_rdy = 1'b1;
`endif
        send("rd7", 1'b0, 8'd7, 128'h0, 16'h0, 8'h78);
        expect_resp("rd7", 1'b0, 8'h78, {16{8'h5A}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
